bullet_wave_scheduler: RTL and testbench

Sequences one attack wave across NUM_LANES bullet generator lanes. Runs the wave phases (warm-up, attack, hit-freeze, cool-down) and issues one-hot spawn pulses to free lanes in round-robin order. Tracks player hits and gates each lane's enable. Sits between the game-level FSM (start/done) and the per-lane bullet generators.

---
 rtl/bullet_wave_scheduler.sv | 145 ++++++++++++++
 tb/tb_bullet_wave_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_wave_scheduler.sv
// bullet_wave_scheduler: runs one attack wave (warm-up, attack, hit-freeze, cool-down) over NUM_LANES bullet lanes
// Ports:
//   CLOCK_50          system clock
//   reset             asynchronous active-high reset
//   start             single-cycle wave request, honoured only in IDLE
//   player_collision  level, player overlaps an active bullet
//   lane_active       bullet_active from each lane generator
//   lane_enable       per-lane enable to the generators (registered)
//   lane_spawn        one-hot, one-cycle spawn request (registered)
//   state             encoded FSM state
//   busy              high in every state except IDLE (registered)
//   wave_done         one-cycle pulse at wave end (registered)
//   hit_count         hits this wave, saturating at 15
module bullet_wave_scheduler #(
    parameter int NUM_LANES      = 4,
    parameter int TICK_DIV       = 500000,
    parameter int WARMUP_TICKS   = 50,
    parameter int ATTACK_TICKS   = 1000,
    parameter int SPAWN_PERIOD   = 25,
    parameter int COOLDOWN_TICKS = 50,
    parameter int FREEZE_TICKS   = 100
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 player_collision,
    input  logic [NUM_LANES-1:0] lane_active,
    output logic [NUM_LANES-1:0] lane_enable,
    output logic [NUM_LANES-1:0] lane_spawn,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 wave_done,
    output logic [3:0]           hit_count
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int PHMAX = (WARMUP_TICKS > FREEZE_TICKS) ?
                           ((WARMUP_TICKS > COOLDOWN_TICKS) ? WARMUP_TICKS : COOLDOWN_TICKS) :
                           ((FREEZE_TICKS > COOLDOWN_TICKS) ? FREEZE_TICKS : COOLDOWN_TICKS);
    localparam int CW = $clog2(PHMAX + 1);
    localparam int AW = $clog2(ATTACK_TICKS + 1);
    localparam int SW = $clog2(SPAWN_PERIOD + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WARMUP   = 3'd1,
        ATTACK   = 3'd2,
        FREEZE   = 3'd3,
        COOLDOWN = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t               st, st_n;
    logic [PW-1:0]        presc;
    logic [CW-1:0]        phase;
    logic [AW-1:0]        elapsed;
    logic [SW-1:0]        spawn_timer;
    logic [LW-1:0]        ptr, ptr_n, sel, idx;
    logic [3:0]           hit_n;
    logic [NUM_LANES-1:0] spawn_n;
    logic                 tick, found;

    assign tick  = (presc == PW'(TICK_DIV - 1));
    assign state = st;

    // First free lane at or after the round-robin pointer, wrapping; the
    // loop runs downward so the closest candidate is the last one written.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = LW'((int'(ptr) + k) % NUM_LANES);
            if (!lane_active[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        st_n    = st;
        ptr_n   = ptr;
        hit_n   = hit_count;
        spawn_n = '0;
        case (st)
            IDLE: begin
                if (start) begin
                    st_n  = WARMUP;
                    ptr_n = '0;
                    hit_n = '0;
                end
            end
            WARMUP:   st_n = (tick && phase == CW'(WARMUP_TICKS - 1)) ? ATTACK : st;
            ATTACK: begin
                // A hit outranks the tick, the spawn decision and the attack end.
                if (player_collision) begin
                    st_n  = FREEZE;
                    hit_n = (hit_count == 4'hF) ? hit_count : hit_count + 4'd1;
                end else if (tick) begin
                    if (elapsed == AW'(ATTACK_TICKS - 1))
                        st_n = COOLDOWN;
                    else if (spawn_timer == SW'(SPAWN_PERIOD - 1) && found) begin
                        spawn_n = {{(NUM_LANES - 1){1'b0}}, 1'b1} << sel;
                        ptr_n   = (sel == LW'(NUM_LANES - 1)) ? '0 : sel + LW'(1);
                    end
                end
            end
            FREEZE:   st_n = (tick && phase == CW'(FREEZE_TICKS - 1)) ? ATTACK : st;
            COOLDOWN: st_n = (tick && phase == CW'(COOLDOWN_TICKS - 1)) ? DONE : st;
            DONE:     st_n = IDLE;
            default:  st_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            presc       <= '0;
            phase       <= '0;
            elapsed     <= '0;
            spawn_timer <= '0;
            ptr         <= '0;
            hit_count   <= '0;
            lane_spawn  <= '0;
            lane_enable <= '0;
            busy        <= 1'b0;
            wave_done   <= 1'b0;
        end else begin
            st          <= st_n;
            presc       <= (st_n != st || st == IDLE || tick) ? '0 : presc + PW'(1);
            phase       <= (st_n != st) ? '0 : tick ? phase + CW'(1) : phase;
            elapsed     <= (st == IDLE) ? '0 :
                           (st == ATTACK && !player_collision && tick) ? elapsed + AW'(1) : elapsed;
            spawn_timer <= (st != ATTACK || st_n != ATTACK || (tick && spawn_timer == SW'(SPAWN_PERIOD - 1))) ? '0 :
                           tick ? spawn_timer + SW'(1) : spawn_timer;
            ptr         <= ptr_n;
            hit_count   <= hit_n;
            lane_spawn  <= spawn_n;
            lane_enable <= (st_n == ATTACK || st_n == COOLDOWN) ? '1 : '0;
            busy        <= (st_n != IDLE);
            wave_done   <= (st_n == DONE);
        end
    end
endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// tb_bullet_wave_scheduler: table-driven and scoreboard bench for bullet_wave_scheduler
module tb_bullet_wave_scheduler;
    localparam int N = 4;
    localparam int F = 15;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         player_collision = 1'b0;
    logic [N-1:0] lane_active = '0;
    logic [N-1:0] lane_enable, lane_spawn;
    logic [2:0]   state;
    logic         busy, wave_done;
    logic [3:0]   hit_count;

    always #5 CLOCK_50 = ~CLOCK_50;

    bullet_wave_scheduler #(
        .NUM_LANES(N), .TICK_DIV(4), .WARMUP_TICKS(2), .ATTACK_TICKS(20),
        .SPAWN_PERIOD(5), .COOLDOWN_TICKS(3), .FREEZE_TICKS(4)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .player_collision(player_collision), .lane_active(lane_active),
        .lane_enable(lane_enable), .lane_spawn(lane_spawn), .state(state),
        .busy(busy), .wave_done(wave_done), .hit_count(hit_count)
    );

    typedef struct {int cyc; int st; int en; int sp; int bz; int wd; int hc;} vec_t;
    typedef struct {int cyc; int lane;} spawn_t;

    vec_t   vecs[$];
    spawn_t exp_sp[$];
    int     cyc, checks, passed;
    string  tname;

    task automatic check(input string n, input int a, input int e);
        checks++;
        if (a == e) passed++;
        else $display("FAIL %s/%s cyc=%0d: got %0d expected %0d", tname, n, cyc, a, e);
    endtask

    task automatic add(input int c, input int st, input int en, input int sp, input int bz, input int wd, input int hc);
        vecs.push_back('{c, st, en, sp, bz, wd, hc});
    endtask

    task automatic want_spawn(input int c, input int lane);
        exp_sp.push_back('{c, lane});
    endtask

    task automatic step();
        spawn_t s;
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (lane_spawn != '0) begin
            check("spawn_onehot", int'($onehot(lane_spawn)), 1);
            if (exp_sp.size() == 0) check("spawn_unexpected", int'(lane_spawn), 0);
            else begin
                s = exp_sp.pop_front();
                check("spawn_cyc", cyc, s.cyc);
                check("spawn_lane", int'(lane_spawn), s.lane);
            end
        end
        foreach (vecs[i]) if (vecs[i].cyc == cyc) begin
            check("state", int'(state), vecs[i].st);
            check("lane_enable", int'(lane_enable), vecs[i].en);
            check("lane_spawn", int'(lane_spawn), vecs[i].sp);
            check("busy", int'(busy), vecs[i].bz);
            check("wave_done", int'(wave_done), vecs[i].wd);
            check("hit_count", int'(hit_count), vecs[i].hc);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic begin_test(input string n);
        tname = n;
        vecs.delete();
        exp_sp.delete();
        cyc = 0;
    endtask

    task automatic end_test();
        check("spawn_missing", exp_sp.size(), 0);
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic hit_at(input int c);
        run_to(c);
        player_collision = 1'b1;
        step();
        player_collision = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_state", int'(state), 0);
        check("rst_enable", int'(lane_enable), 0);
        check("rst_spawn", int'(lane_spawn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(wave_done), 0);
        check("rst_hits", int'(hit_count), 0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        cyc = 0;
        tname = "reset";
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_reset_values();
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;

        begin_test("nominal");
        add(1, 1, 0, 0, 1, 0, 0);   add(8, 1, 0, 0, 1, 0, 0);
        add(9, 2, F, 0, 1, 0, 0);   add(28, 2, F, 0, 1, 0, 0);
        add(29, 2, F, 1, 1, 0, 0);  add(49, 2, F, 2, 1, 0, 0);
        add(69, 2, F, 4, 1, 0, 0);  add(88, 2, F, 0, 1, 0, 0);
        add(89, 4, F, 0, 1, 0, 0);  add(100, 4, F, 0, 1, 0, 0);
        add(101, 5, 0, 0, 1, 1, 0); add(102, 0, 0, 0, 0, 0, 0);
        want_spawn(29, 1); want_spawn(49, 2); want_spawn(69, 4);
        launch();
        run_to(103);
        end_test();

        begin_test("occupied");
        add(29, 2, F, 4, 1, 0, 0); add(49, 2, F, 8, 1, 0, 0); add(89, 4, F, 0, 1, 0, 0);
        want_spawn(29, 4); want_spawn(49, 8); want_spawn(69, 4);
        lane_active = 4'b0011;
        launch();
        run_to(103);
        end_test();

        begin_test("all_busy");
        add(29, 2, F, 0, 1, 0, 0); add(49, 2, F, 1, 1, 0, 0);
        want_spawn(49, 1); want_spawn(69, 2);
        lane_active = 4'b1111;
        launch();
        run_to(29);
        lane_active = 4'b0000;
        run_to(103);
        end_test();

        begin_test("hit");
        add(36, 2, F, 0, 1, 0, 0);  add(37, 3, 0, 0, 1, 0, 1);
        add(39, 3, 0, 0, 1, 0, 1);  add(52, 3, 0, 0, 1, 0, 1);
        add(53, 2, F, 0, 1, 0, 1);  add(73, 2, F, 2, 1, 0, 1);
        add(93, 2, F, 4, 1, 0, 1);  add(108, 2, F, 0, 1, 0, 1);
        add(109, 4, F, 0, 1, 0, 1); add(121, 5, 0, 0, 1, 1, 1);
        add(122, 0, 0, 0, 0, 0, 1);
        want_spawn(29, 1); want_spawn(73, 2); want_spawn(93, 4);
        launch();
        run_to(36);
        player_collision = 1'b1;
        run_to(39);
        player_collision = 1'b0;
        run_to(123);
        end_test();

        begin_test("saturate");
        add(247, 2, F, 0, 1, 0, 14); add(248, 3, 0, 0, 1, 0, 15);
        add(264, 2, F, 0, 1, 0, 15); add(265, 3, 0, 0, 1, 0, 15);
        add(281, 2, F, 0, 1, 0, 15); add(360, 2, F, 0, 1, 0, 15);
        add(361, 4, F, 0, 1, 0, 15); add(366, 4, F, 0, 1, 0, 15);
        add(372, 4, F, 0, 1, 0, 15); add(373, 5, 0, 0, 1, 1, 15);
        add(374, 0, 0, 0, 0, 0, 15);
        want_spawn(301, 1); want_spawn(321, 2); want_spawn(341, 4);
        launch();
        for (int k = 0; k < 16; k++) hit_at(9 + 17 * k);
        hit_at(365);
        run_to(375);
        end_test();

        begin_test("async_reset");
        add(30, 2, F, 0, 1, 0, 1);
        launch();
        hit_at(10);
        run_to(30);
        end_test();
        #3;
        reset = 1'b1;
        #1;
        check_reset_values();
        @(posedge CLOCK_50);
        #3;
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("post_reset_state", int'(state), 0);

        begin_test("fresh_wave");
        add(1, 1, 0, 0, 1, 0, 0);  add(9, 2, F, 0, 1, 0, 0);
        add(29, 2, F, 1, 1, 0, 0); add(101, 5, 0, 0, 1, 1, 0);
        want_spawn(29, 1); want_spawn(49, 2); want_spawn(69, 4);
        launch();
        run_to(103);
        end_test();

        begin_test("start_ignored");
        add(5, 1, 0, 0, 1, 0, 0);    add(8, 1, 0, 0, 1, 0, 0);
        add(9, 2, F, 0, 1, 0, 0);    add(11, 3, 0, 0, 1, 0, 1);
        add(106, 2, F, 0, 1, 0, 1);  add(111, 4, F, 0, 1, 0, 1);
        add(118, 4, F, 0, 1, 0, 1);  add(119, 5, 0, 0, 1, 1, 1);
        add(120, 0, 0, 0, 0, 0, 1);
        want_spawn(47, 1); want_spawn(67, 2); want_spawn(87, 4);
        launch();
        run_to(4);
        start = 1'b1;
        step();
        start = 1'b0;
        hit_at(10);
        run_to(110);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(121);
        end_test();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
